// File: rtl/bus_demultiplexer1to4_nbits_if.sv
`default_nettype none
// ============================================================================
// bus_demultiplexer1to4_nbits_if : producer bus, four consumer channels, counters
// Revision: 1.0
// ============================================================================
interface bus_demultiplexer1to4_nbits_if #(
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = 8
);
    logic [BUS_WIDTH-1:0] A;
    logic [1:0]           SEL;
    logic                 IN_VALID;
    logic                 IN_READY;
    logic [BUS_WIDTH-1:0] Y0;
    logic [BUS_WIDTH-1:0] Y1;
    logic [BUS_WIDTH-1:0] Y2;
    logic [BUS_WIDTH-1:0] Y3;
    logic [3:0]           Y_VALID;
    logic [3:0]           Y_READY;
    logic                 CLR_CNT;
    logic [CNT_WIDTH-1:0] CNT0;
    logic [CNT_WIDTH-1:0] CNT1;
    logic [CNT_WIDTH-1:0] CNT2;
    logic [CNT_WIDTH-1:0] CNT3;

    modport slave (
        input  A, SEL, IN_VALID, Y_READY, CLR_CNT,
        output IN_READY, Y0, Y1, Y2, Y3, Y_VALID, CNT0, CNT1, CNT2, CNT3
    );

    modport master (
        output A, SEL, IN_VALID, Y_READY, CLR_CNT,
        input  IN_READY, Y0, Y1, Y2, Y3, Y_VALID, CNT0, CNT1, CNT2, CNT3
    );
endinterface
`default_nettype wire

// File: rtl/bus_demultiplexer1to4_nbits.sv
`default_nettype none
// ============================================================================
// bus_demultiplexer1to4_nbits : registered 1-to-4 demux, valid/ready per channel
// Revision: 1.0
// ============================================================================
module bus_demultiplexer1to4_nbits #(
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = 8
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    bus_demultiplexer1to4_nbits_if.slave    bus
);
    logic [BUS_WIDTH-1:0] data_q [4];
    logic [CNT_WIDTH-1:0] cnt_q  [4];
    logic [3:0]           valid_q;
    logic                 in_ready;
    logic                 in_fire;
    logic [3:0]           out_fire;

    // Only the addressed channel can stall the producer.
    assign in_ready = ~valid_q[bus.SEL] | bus.Y_READY[bus.SEL];
    assign in_fire  = bus.IN_VALID & in_ready;
    assign out_fire = valid_q & bus.Y_READY;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                // A load wins over a drain so a full channel can stream without a bubble.
                if (in_fire && (bus.SEL == 2'(i))) begin
                    data_q[i]  <= bus.A;
                    valid_q[i] <= 1'b1;
                end else if (out_fire[i]) begin
                    valid_q[i] <= 1'b0;
                end

                if (bus.CLR_CNT) begin
                    cnt_q[i] <= '0;
                end else if (out_fire[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign bus.IN_READY = in_ready;
    assign bus.Y_VALID  = valid_q;
    assign bus.Y0       = data_q[0];
    assign bus.Y1       = data_q[1];
    assign bus.Y2       = data_q[2];
    assign bus.Y3       = data_q[3];
    assign bus.CNT0     = cnt_q[0];
    assign bus.CNT1     = cnt_q[1];
    assign bus.CNT2     = cnt_q[2];
    assign bus.CNT3     = cnt_q[3];

endmodule
`default_nettype wire

// File: tb/tb_bus_demultiplexer1to4_nbits.sv
`default_nettype none
// ============================================================================
// tb_bus_demultiplexer1to4_nbits : vector table plus reset and counter-wrap sequences
// Revision: 1.0
// ============================================================================
module tb_bus_demultiplexer1to4_nbits;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    bus_demultiplexer1to4_nbits_if #(.BUS_WIDTH(8), .CNT_WIDTH(8)) bus ();

    bus_demultiplexer1to4_nbits #(.BUS_WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [1:0] sel;
        logic [7:0] a;
        logic [3:0] yr;
        logic       clr;
        logic       e_rdy;
        logic [3:0] e_v;
        logic [7:0] e0, e1, e2, e3;
        logic [7:0] c0, c1, c2, c3;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [1:0] sel, input logic [7:0] a,
                         input logic [3:0] yr, input logic clr);
        bus.IN_VALID = iv;
        bus.SEL      = sel;
        bus.A        = a;
        bus.Y_READY  = yr;
        bus.CLR_CNT  = clr;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " Y0"}, 32'(bus.Y0), 32'h0);
        chk({tag, " Y1"}, 32'(bus.Y1), 32'h0);
        chk({tag, " Y2"}, 32'(bus.Y2), 32'h0);
        chk({tag, " Y3"}, 32'(bus.Y3), 32'h0);
        chk({tag, " Y_VALID"}, 32'(bus.Y_VALID), 32'h0);
        chk({tag, " CNT"}, {bus.CNT0, bus.CNT1, bus.CNT2, bus.CNT3}, 32'h0);
        chk({tag, " IN_READY"}, 32'(bus.IN_READY), 32'h1);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);

        //            iv   sel   a      yr       clr   rdy   valid    Y0     Y1     Y2     Y3     C0    C1    C2    C3
        vecs[0]  = '{1'b1, 2'd0, 8'h18, 4'b0000, 1'b0, 1'b1, 4'b0001, 8'h18, 8'h00, 8'h00, 8'h00, 8'd0, 8'd0, 8'd0, 8'd0};
        vecs[1]  = '{1'b1, 2'd1, 8'hD8, 4'b0000, 1'b0, 1'b1, 4'b0011, 8'h18, 8'hD8, 8'h00, 8'h00, 8'd0, 8'd0, 8'd0, 8'd0};
        vecs[2]  = '{1'b1, 2'd2, 8'h00, 4'b0000, 1'b0, 1'b1, 4'b0111, 8'h18, 8'hD8, 8'h00, 8'h00, 8'd0, 8'd0, 8'd0, 8'd0};
        vecs[3]  = '{1'b1, 2'd3, 8'h1B, 4'b0000, 1'b0, 1'b1, 4'b1111, 8'h18, 8'hD8, 8'h00, 8'h1B, 8'd0, 8'd0, 8'd0, 8'd0};
        vecs[4]  = '{1'b1, 2'd2, 8'hAA, 4'b0000, 1'b0, 1'b0, 4'b1111, 8'h18, 8'hD8, 8'h00, 8'h1B, 8'd0, 8'd0, 8'd0, 8'd0};
        vecs[5]  = '{1'b0, 2'd0, 8'hEE, 4'b0001, 1'b0, 1'b1, 4'b1110, 8'h18, 8'hD8, 8'h00, 8'h1B, 8'd1, 8'd0, 8'd0, 8'd0};
        vecs[6]  = '{1'b1, 2'd2, 8'hAA, 4'b0000, 1'b0, 1'b0, 4'b1110, 8'h18, 8'hD8, 8'h00, 8'h1B, 8'd1, 8'd0, 8'd0, 8'd0};
        vecs[7]  = '{1'b1, 2'd0, 8'hAA, 4'b0000, 1'b0, 1'b1, 4'b1111, 8'hAA, 8'hD8, 8'h00, 8'h1B, 8'd1, 8'd0, 8'd0, 8'd0};
        vecs[8]  = '{1'b1, 2'd1, 8'h3C, 4'b0010, 1'b0, 1'b1, 4'b1111, 8'hAA, 8'h3C, 8'h00, 8'h1B, 8'd1, 8'd1, 8'd0, 8'd0};
        vecs[9]  = '{1'b0, 2'd0, 8'h99, 4'b1111, 1'b0, 1'b1, 4'b0000, 8'hAA, 8'h3C, 8'h00, 8'h1B, 8'd2, 8'd2, 8'd1, 8'd1};
        vecs[10] = '{1'b0, 2'd0, 8'h99, 4'b1111, 1'b0, 1'b1, 4'b0000, 8'hAA, 8'h3C, 8'h00, 8'h1B, 8'd2, 8'd2, 8'd1, 8'd1};
        vecs[11] = '{1'b1, 2'd3, 8'h55, 4'b1000, 1'b0, 1'b1, 4'b1000, 8'hAA, 8'h3C, 8'h00, 8'h55, 8'd2, 8'd2, 8'd1, 8'd1};
        vecs[12] = '{1'b1, 2'd3, 8'h66, 4'b1000, 1'b0, 1'b1, 4'b1000, 8'hAA, 8'h3C, 8'h00, 8'h66, 8'd2, 8'd2, 8'd1, 8'd2};
        vecs[13] = '{1'b0, 2'd0, 8'h00, 4'b1000, 1'b1, 1'b1, 4'b0000, 8'hAA, 8'h3C, 8'h00, 8'h66, 8'd0, 8'd0, 8'd0, 8'd0};
        vecs[14] = '{1'b1, 2'd0, 8'h77, 4'b0000, 1'b0, 1'b1, 4'b0001, 8'h77, 8'h3C, 8'h00, 8'h66, 8'd0, 8'd0, 8'd0, 8'd0};
        vecs[15] = '{1'b0, 2'd0, 8'h00, 4'b0001, 1'b1, 1'b1, 4'b0000, 8'h77, 8'h3C, 8'h00, 8'h66, 8'd0, 8'd0, 8'd0, 8'd0};

        #2;
        check_reset_state("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].iv, vecs[i].sel, vecs[i].a, vecs[i].yr, vecs[i].clr);
            #1;
            chk($sformatf("v%0d IN_READY", i), 32'(bus.IN_READY), 32'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d Y_VALID", i), 32'(bus.Y_VALID), 32'(vecs[i].e_v));
            chk($sformatf("v%0d Y0..Y3", i), {bus.Y0, bus.Y1, bus.Y2, bus.Y3},
                {vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3});
            chk($sformatf("v%0d CNT0..3", i), {bus.CNT0, bus.CNT1, bus.CNT2, bus.CNT3},
                {vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].c3});
        end

        // Mid-stream asynchronous reset with channels 0 and 2 occupied.
        drive(1'b1, 2'd0, 8'h11, 4'b0000, 1'b0);
        @(posedge clk);
        #1 drive(1'b1, 2'd2, 8'h22, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        chk("pre-reset Y_VALID", 32'(bus.Y_VALID), 32'b0101);
        bus.Y_READY = 4'b1111;
        rst_n = 1'b0;
        #1;
        check_reset_state("async reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b0, 2'd3, 8'h00, 4'b0000, 1'b0);

        // 256 words through channel 3 with the consumer always ready.
        for (int k = 0; k < 256; k++) begin
            drive(1'b1, 2'd3, 8'(k), 4'b1000, 1'b0);
            @(posedge clk);
            #1;
        end
        chk("wrap pre CNT3", 32'(bus.CNT3), 32'd255);
        chk("wrap pre Y3", 32'(bus.Y3), 32'hFF);
        drive(1'b0, 2'd3, 8'h00, 4'b1000, 1'b0);
        @(posedge clk);
        #1;
        chk("wrap CNT3", 32'(bus.CNT3), 32'd0);
        chk("wrap Y_VALID", 32'(bus.Y_VALID), 32'b0000);

        drive(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
